// File: rtl/fifo_rd_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side controller of an asynchronous FIFO, running in the rd_clk domain.
// Compares the synchronized Gray write pointer with the local read pointer,
// issues reads to a dual-port memory with 1-cycle read latency, and presents
// the data through a 2-entry valid/ready buffer at up to one word per cycle.
// The registered Gray read pointer is exported to the write-domain synchronizer.
//
// Ports
//   rd_clk        read-domain clock
//   rst           synchronous active-low reset
//   sync_wr_ptr   Gray write pointer, already synchronized to rd_clk
//   mem_rd_en     memory read strobe (combinational)
//   mem_rd_addr   memory read address (low bits of the binary read pointer)
//   mem_rd_data   memory data, valid one cycle after mem_rd_en
//   rd_valid      output word valid
//   rd_ready      consumer accepts the word
//   rd_data       output word (oldest buffered entry)
//   gr_rd_ptr     registered Gray read pointer, to the write domain
//   empty         nothing in memory, in flight or buffered
//   almost_empty  rd_count <= AEMPTY_TH
//   rd_count      words available to the consumer
// ---------------------------------------------------------------------------
module fifo_rd_ctrl #(
  parameter int ADDR      = 4,
  parameter int DATA_W    = 8,
  parameter int AEMPTY_TH = 2
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic [ADDR:0]     sync_wr_ptr,
  output logic              mem_rd_en,
  output logic [ADDR-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR:0]     gr_rd_ptr,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR+1:0]   rd_count
);

  localparam logic [ADDR:0]   PTR_ONE = (ADDR+1)'(1);
  localparam logic [ADDR+1:0] AE_CNT  = (ADDR+2)'(AEMPTY_TH);

  // Buffer occupancy doubles as the state encoding, so buf_cnt is the state.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  buf_state_t        buf_state_reg, buf_state_next;
  logic [ADDR:0]     rd_ptr_reg, rd_ptr_next;
  logic [ADDR:0]     gr_rd_ptr_reg, gr_rd_ptr_next;
  logic              inflight_reg, inflight_next;
  logic [DATA_W-1:0] head_reg, head_next;
  logic [DATA_W-1:0] tail_reg, tail_next;

  logic [ADDR:0]     wr_bin;
  logic [ADDR:0]     rd_ptr_inc;
  logic [ADDR:0]     mem_diff;
  logic [1:0]        buf_cnt;
  logic              mem_empty;
  logic              pop;
  logic              ret;
  logic              room;
  logic              issue;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi <= ADDR; gi++) begin : g_gray2bin
      assign wr_bin[gi] = ^sync_wr_ptr[ADDR:gi];
    end
  endgenerate

  assign buf_cnt    = buf_state_reg;
  assign mem_empty  = (wr_bin == rd_ptr_reg);
  assign pop        = rd_valid & rd_ready;
  assign ret        = inflight_reg;
  assign rd_ptr_inc = rd_ptr_reg + PTR_ONE;

  // Free buffer slots once the in-flight word lands; a pop this cycle frees
  // one more, which is what sustains one word per cycle.
  assign room  = (buf_state_reg == BUF_EMPTY) |
                 ((buf_state_reg == BUF_ONE) & ~inflight_reg);
  // Gating with rst keeps the memory quiet while reset is held.
  assign issue = rst & ~mem_empty & (room | pop);

  always_comb begin
    rd_ptr_next    = rd_ptr_reg;
    gr_rd_ptr_next = gr_rd_ptr_reg;
    inflight_next  = issue;
    buf_state_next = buf_state_reg;
    head_next      = head_reg;
    tail_next      = tail_reg;

    if (issue) begin
      rd_ptr_next    = rd_ptr_inc;
      gr_rd_ptr_next = rd_ptr_inc ^ (rd_ptr_inc >> 1);
    end

    case (buf_state_reg)
      BUF_EMPTY: begin
        if (ret) begin
          head_next      = mem_rd_data;
          buf_state_next = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (ret & pop) begin
          head_next = mem_rd_data;
        end else if (ret) begin
          tail_next      = mem_rd_data;
          buf_state_next = BUF_TWO;
        end else if (pop) begin
          buf_state_next = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        // A return while full is only possible together with a pop.
        if (pop) begin
          head_next = tail_reg;
          if (ret) begin
            tail_next = mem_rd_data;
          end else begin
            buf_state_next = BUF_ONE;
          end
        end
      end
      default: buf_state_next = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (!rst) begin
      buf_state_reg <= BUF_EMPTY;
      rd_ptr_reg    <= '0;
      gr_rd_ptr_reg <= '0;
      inflight_reg  <= 1'b0;
      head_reg      <= '0;
      tail_reg      <= '0;
    end else begin
      buf_state_reg <= buf_state_next;
      rd_ptr_reg    <= rd_ptr_next;
      gr_rd_ptr_reg <= gr_rd_ptr_next;
      inflight_reg  <= inflight_next;
      head_reg      <= head_next;
      tail_reg      <= tail_next;
    end
  end

  assign mem_rd_en    = issue;
  assign mem_rd_addr  = rd_ptr_reg[ADDR-1:0];
  assign rd_valid     = (buf_state_reg != BUF_EMPTY);
  assign rd_data      = head_reg;
  assign gr_rd_ptr    = gr_rd_ptr_reg;
  assign mem_diff     = wr_bin - rd_ptr_reg;
  assign rd_count     = {1'b0, mem_diff} + {{ADDR{1'b0}}, buf_cnt} +
                        {{(ADDR+1){1'b0}}, inflight_reg};
  assign empty        = mem_empty & (buf_state_reg == BUF_EMPTY) & ~inflight_reg;
  assign almost_empty = (rd_count <= AE_CNT);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
`timescale 1ns/1ps
// Testbench for fifo_rd_ctrl: a write-side model fills a memory array and
// pushes each word into a scoreboard queue; a negedge monitor compares every
// popped word and the status outputs against the queue contents.
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] sync_wr_ptr = '0;
  logic       mem_rd_en;
  logic [3:0] mem_rd_addr;
  logic [7:0] mem_rd_data = '0;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic [4:0] gr_rd_ptr;
  logic       empty;
  logic       almost_empty;
  logic [5:0] rd_count;

  fifo_rd_ctrl #(.ADDR(4), .DATA_W(8), .AEMPTY_TH(2)) dut (
    .rd_clk       (clk),
    .rst          (rst),
    .sync_wr_ptr  (sync_wr_ptr),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .gr_rd_ptr    (gr_rd_ptr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];
  logic [7:0] exp_q [$];
  logic [4:0] wr_ptr = '0;
  int         wr_cnt = 0;

  // Memory model: 1-cycle read latency, junk on the bus when not reading.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    else           mem_rd_data <= 8'($urandom);
  end

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int         issued = 0;
  bit         hold = 0;
  logic [7:0] held = '0;

  always @(negedge clk) begin
    if (!rst) begin
      issued = 0;
      hold   = 0;
    end else begin
      chk("rd_count", 32'(rd_count), exp_q.size());
      chk("empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("almost_empty", 32'(almost_empty), 32'(exp_q.size() <= 2));
      chk("gr_rd_ptr", 32'(gr_rd_ptr), 32'(gray5(5'(issued))));
      chk("occupancy", 32'((issued - (wr_cnt - exp_q.size())) <= 2), 1);
      if (hold) begin
        chk("hold_valid", 32'(rd_valid), 1);
        chk("hold_data", 32'(rd_data), 32'(held));
      end
      if (mem_rd_en) begin
        chk("rd_addr", 32'(mem_rd_addr), 32'(issued % 16));
        issued++;
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_underflow got data %0h expected no valid at %0t", rd_data, $time);
        end else begin
          chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
      end
      hold = rd_valid && !rd_ready;
      held = rd_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int k);
    for (int i = 0; i < k; i++) begin
      mem[wr_ptr[3:0]] = 8'($urandom);
      exp_q.push_back(mem[wr_ptr[3:0]]);
      wr_ptr = wr_ptr + 5'd1;
      wr_cnt++;
    end
    sync_wr_ptr = gray5(wr_ptr);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rd_ready = 1'b0;
    wr_ptr = '0;
    wr_cnt = 0;
    sync_wr_ptr = '0;
    exp_q.delete();
    next_slot();
    @(negedge clk);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_gr", 32'(gr_rd_ptr), 0);
    chk("rst_count", 32'(rd_count), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    next_slot();
    rst = 1'b1;
  endtask

  initial begin
    int en_exp[6]    = '{1, 1, 1, 0, 0, 0};
    int val_exp[6]   = '{0, 0, 1, 1, 1, 0};
    int addr_exp[4]  = '{14, 15, 0, 1};
    int gr_exp[4]    = '{5'b10001, 5'b10000, 5'b00000, 5'b00001};
    logic [7:0] first;
    int k;

    next_slot();
    do_reset();

    // Three words from idle: reads on t..t+2, valid on t+2..t+4.
    next_slot();
    rd_ready = 1'b1;
    push_words(3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_rd_en", 32'(mem_rd_en), en_exp[i]);
      chk("t2_valid", 32'(rd_valid), val_exp[i]);
      chk("t2_empty", 32'(empty), 32'(i == 5));
      next_slot();
    end

    // Five words with the consumer stalled: only two reads go out.
    do_reset();
    next_slot();
    push_words(5);
    first = exp_q[0];
    repeat (5) next_slot();
    @(negedge clk);
    chk("t3_gr", 32'(gr_rd_ptr), 5'b00011);
    chk("t3_count", 32'(rd_count), 5);
    chk("t3_valid", 32'(rd_valid), 1);
    chk("t3_data", 32'(rd_data), 32'(first));
    chk("t3_rd_en", 32'(mem_rd_en), 0);
    next_slot();
    rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_stream", 32'(rd_valid), 32'(i < 5));
      next_slot();
    end

    // Full memory plus full buffer: rd_count reaches 2**ADDR + 2.
    do_reset();
    next_slot();
    push_words(16);
    repeat (4) next_slot();
    push_words(2);
    repeat (3) next_slot();
    @(negedge clk);
    chk("max_count", 32'(rd_count), 18);
    next_slot();
    rd_ready = 1'b1;
    repeat (25) next_slot();
    @(negedge clk);
    chk("max_drained", 32'(rd_count), 0);
    next_slot();

    // Pointer wrap: stream 30 words, then 4 more across the 31 -> 0 boundary.
    do_reset();
    next_slot();
    rd_ready = 1'b1;
    while (wr_cnt < 30) begin
      push_words((wr_cnt + 2 <= 30) ? 2 : 1);
      next_slot();
    end
    repeat (30) next_slot();
    @(negedge clk);
    chk("t4_gr30", 32'(gr_rd_ptr), 5'b10001);
    chk("t4_count0", 32'(rd_count), 0);
    next_slot();
    push_words(4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_rd_en", 32'(mem_rd_en), 1);
      chk("t4_addr", 32'(mem_rd_addr), addr_exp[i]);
      chk("t4_gr", 32'(gr_rd_ptr), gr_exp[i]);
      next_slot();
    end
    repeat (8) next_slot();

    // Reset with a read in flight: the returning word must not appear.
    do_reset();
    next_slot();
    rd_ready = 1'b1;
    push_words(1);
    next_slot();
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_stale", 32'(rd_valid), 0);
      next_slot();
    end
    // Reset with a full buffer.
    push_words(5);
    rd_ready = 1'b0;
    repeat (4) next_slot();
    do_reset();
    @(negedge clk);
    chk("t5_full_valid", 32'(rd_valid), 0);
    chk("t5_full_count", 32'(rd_count), 0);
    next_slot();

    // Drain from 4: almost_empty at 2, empty only after the last pop.
    do_reset();
    next_slot();
    push_words(4);
    repeat (4) next_slot();
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_count", 32'(rd_count), 4 - i);
      chk("t6_aempty", 32'(almost_empty), 32'((4 - i) <= 2));
      chk("t6_empty", 32'(empty), 32'(i == 4));
      next_slot();
    end

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      next_slot();
      rd_ready = ($urandom_range(0, 3) != 0) && ((n / 200) % 3 != 2);
      k = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1 && exp_q.size() + k <= 16) push_words(k);
    end
    next_slot();
    rd_ready = 1'b1;
    repeat (40) next_slot();
    chk("final_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
